// File: rtl/esp_resp_parser.sv
// esp_resp_parser
// Assembles CR/LF-terminated response lines from an ESP-style modem UART.
// It holds each completed line so a consumer can read it, and flags the
// exact responses "OK" and "ERROR".
//
// Ports
//   clk, rst            single clock; synchronous active-high reset
//   rx_data, rx_valid   received byte and its one-cycle strobe
//   rd_addr, rd_data    byte read port into the held line (1-cycle latency)
//   line_len            length of the held line, 0 when nothing is held
//   line_ready          level: a complete line is held
//   line_ack            consumer pulse that releases the held line
//   resp_ok/resp_error  one-cycle pulse when the held line is "OK"/"ERROR"
//   overflow            one-cycle pulse: a line was too long and was dropped
//   overrun             sticky: a byte arrived while a line was held
//
// State | meaning
// IDLE    | waiting for the first byte of a line (CR/LF skipped)
// COLLECT | storing bytes of the current line
// DISCARD | line exceeded LINE_MAX, dropping bytes until LF
// HOLD    | complete line held for the consumer, input bytes dropped
module esp_resp_parser #(
    parameter int LINE_MAX = 32,
    parameter int AW       = 6
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [7:0]    rx_data,
    input  logic          rx_valid,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data,
    output logic [AW-1:0] line_len,
    output logic          line_ready,
    input  logic          line_ack,
    output logic          resp_ok,
    output logic          resp_error,
    output logic          overflow,
    output logic          overrun
);

    typedef enum logic [1:0] {IDLE, COLLECT, DISCARD, HOLD} state_t;

    localparam logic [AW-1:0] LMAX = AW'(LINE_MAX);

    state_t        state, state_d;
    logic [AW-1:0] len, len_d;
    logic          wr_en;
    logic          ok_d, err_d, ovf_d, ovr_set;
    logic          is_cr, is_lf;
    logic          match_ok, match_err;

    // Array is sized by the full address space so any rd_addr is in range.
    logic [7:0] mem [2**AW];

    assign is_cr = (rx_data == 8'h0D);
    assign is_lf = (rx_data == 8'h0A);

    // The line bytes are already stored when its LF arrives, so matching is
    // done on the buffer and registered alongside the move into HOLD.
    assign match_ok  = (len == AW'(2)) && (mem[0] == 8'h4F) && (mem[1] == 8'h4B);
    assign match_err = (len == AW'(5)) && (mem[0] == 8'h45) && (mem[1] == 8'h52) &&
                       (mem[2] == 8'h52) && (mem[3] == 8'h4F) && (mem[4] == 8'h52);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            len        <= '0;
            resp_ok    <= 1'b0;
            resp_error <= 1'b0;
            overflow   <= 1'b0;
            overrun    <= 1'b0;
            rd_data    <= 8'h00;
        end else begin
            state      <= state_d;
            len        <= len_d;
            resp_ok    <= ok_d;
            resp_error <= err_d;
            overflow   <= ovf_d;
            overrun    <= overrun | ovr_set;
            rd_data    <= mem[rd_addr];
        end
    end

    // len is 0 whenever the FSM is in IDLE, so the write index is always len.
    always_ff @(posedge clk) begin
        if (wr_en && !rst) begin
            mem[len] <= rx_data;
        end
    end

    always_comb begin
        state_d = state;
        len_d   = len;
        wr_en   = 1'b0;
        ok_d    = 1'b0;
        err_d   = 1'b0;
        ovf_d   = 1'b0;
        ovr_set = 1'b0;
        case (state)
            IDLE: begin
                if (rx_valid && !is_cr && !is_lf) begin
                    wr_en   = 1'b1;
                    len_d   = AW'(1);
                    state_d = COLLECT;
                end
            end
            COLLECT: begin
                if (rx_valid) begin
                    if (is_lf) begin
                        state_d = HOLD;
                        ok_d    = match_ok;
                        err_d   = match_err;
                    end else if (!is_cr) begin
                        if (len == LMAX) begin
                            state_d = DISCARD;
                            ovf_d   = 1'b1;
                            len_d   = '0;
                        end else begin
                            wr_en = 1'b1;
                            len_d = len + AW'(1);
                        end
                    end
                end
            end
            DISCARD: begin
                if (rx_valid && is_lf) begin
                    state_d = IDLE;
                end
            end
            HOLD: begin
                if (rx_valid) begin
                    ovr_set = 1'b1;
                end
                if (line_ack) begin
                    state_d = IDLE;
                    len_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
                len_d   = '0;
            end
        endcase
    end

    assign line_ready = (state == HOLD);
    assign line_len   = (state == HOLD) ? len : '0;

endmodule

// File: tb/tb_esp_resp_parser.sv
module tb_esp_resp_parser;

    localparam int LINE_MAX = 32;
    localparam int AW       = 6;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [7:0]    rx_data = 8'h00;
    logic          rx_valid = 1'b0;
    logic [AW-1:0] rd_addr = '0;
    logic [7:0]    rd_data;
    logic [AW-1:0] line_len;
    logic          line_ready;
    logic          line_ack = 1'b0;
    logic          resp_ok, resp_error, overflow, overrun;

    esp_resp_parser #(.LINE_MAX(LINE_MAX), .AW(AW)) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
        .rd_addr(rd_addr), .rd_data(rd_data), .line_len(line_len),
        .line_ready(line_ready), .line_ack(line_ack), .resp_ok(resp_ok),
        .resp_error(resp_error), .overflow(overflow), .overrun(overrun)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Scoreboard: one entry per line that should produce a visible event
    // (line_ready rising, or an overflow pulse).
    typedef struct {
        bit hold;
        bit ok;
        bit err;
        bit ovf;
        int len;
    } evt_t;
    evt_t evq[$];

    typedef struct {
        string txt;   // '~' stands for CR, '|' for LF
        int    len;
        bit    hold;
        bit    ok;
        bit    err;
        bit    ovf;
    } vec_t;
    vec_t vecs[$];

    logic lr_prev = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            lr_prev = 1'b0;
        end else begin
            automatic logic rise = line_ready && !lr_prev;
            if (rise || overflow) begin
                check("evt_expected", (evq.size() > 0), 1);
                if (evq.size() > 0) begin
                    automatic evt_t e = evq.pop_front();
                    check("evt_hold", rise, e.hold);
                    check("evt_ovf", overflow, e.ovf);
                    check("evt_ok", resp_ok, e.ok);
                    check("evt_err", resp_error, e.err);
                    if (e.hold) check("evt_len", line_len, e.len);
                end
            end else if (resp_ok || resp_error) begin
                check("stray_resp", {resp_ok, resp_error}, 0);
            end
            lr_prev = line_ready;
        end
    end

    function automatic logic [7:0] enc(input byte c);
        if (c == "~") return 8'h0D;
        if (c == "|") return 8'h0A;
        return c;
    endfunction

    task automatic drive(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic send_line(input string s);
        for (int i = 0; i < s.len(); i++) drive(enc(s[i]));
        drive(8'h0D);
        drive(8'h0A);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic add_vec(input string t, input int l, input bit h, input bit o, input bit e, input bit v);
        vec_t x;
        x.txt = t; x.len = l; x.hold = h; x.ok = o; x.err = e; x.ovf = v;
        vecs.push_back(x);
    endtask

    task automatic push_evt(input vec_t v);
        evt_t e;
        e.hold = v.hold; e.ok = v.ok; e.err = v.err; e.ovf = v.ovf; e.len = v.len;
        evq.push_back(e);
    endtask

    // Bytes the parser should keep: markers for CR/LF are dropped.
    function automatic string stored(input string s);
        string r = "";
        for (int i = 0; i < s.len(); i++)
            if (s[i] != "~" && s[i] != "|") r = {r, s.substr(i, i)};
        return r;
    endfunction

    task automatic readback(input string tag, input string exp);
        for (int i = 0; i < exp.len(); i++) begin
            rd_addr = AW'(i);
            @(posedge clk);
            #1;
            check({tag, "_rd"}, rd_data, exp[i]);
        end
    endtask

    task automatic ack_line(input string tag);
        check({tag, "_ready_before_ack"}, line_ready, 1);
        line_ack = 1'b1;
        @(posedge clk);
        #1;
        line_ack = 1'b0;
        check({tag, "_ready_after_ack"}, line_ready, 0);
        check({tag, "_len_after_ack"}, line_len, 0);
    endtask

    initial begin
        string a32, a33, exp;
        vec_t  v;

        a32 = "";
        for (int i = 0; i < 32; i++) a32 = {a32, "A"};
        a33 = {a32, "A"};

        add_vec("OK",          2,  1, 1, 0, 0);
        add_vec("ERROR",       5,  1, 0, 1, 0);
        add_vec("WIFI GOT IP", 11, 1, 0, 0, 0);
        add_vec("ok",          2,  1, 0, 0, 0);
        add_vec("ERRORS",      6,  1, 0, 0, 0);
        add_vec("O~K",         2,  1, 1, 0, 0);
        add_vec("|~|OK",       2,  1, 1, 0, 0);
        add_vec("OKK",         3,  1, 0, 0, 0);
        add_vec("ERRO",        4,  1, 0, 0, 0);
        add_vec(a32,           32, 1, 0, 0, 0);
        add_vec(a33,           0,  0, 0, 0, 1);
        add_vec("X",           1,  1, 0, 0, 0);

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_line_ready", line_ready, 0);
        check("rst_line_len", line_len, 0);
        check("rst_overrun", overrun, 0);
        check("rst_rd_data", rd_data, 8'h00);

        // Ack while idle must be ignored.
        line_ack = 1'b1;
        @(posedge clk);
        #1;
        line_ack = 1'b0;
        check("idle_ack_ready", line_ready, 0);

        foreach (vecs[k]) begin
            v = vecs[k];
            push_evt(v);
            send_line(v.txt);
            check({"v_ready_", v.txt}, line_ready, v.hold);
            check({"v_len_", v.txt}, line_len, v.hold ? v.len : 0);
            if (v.hold) begin
                exp = stored(v.txt);
                check({"v_model_len_", v.txt}, exp.len(), v.len);
                readback({"v_", v.txt}, exp);
                ack_line({"v_", v.txt});
            end
            repeat (2) @(posedge clk);
            #1;
        end
        check("no_overrun_yet", overrun, 0);

        // Byte arriving during HOLD: dropped, overrun set, line intact.
        v.txt = "HI"; v.len = 2; v.hold = 1; v.ok = 0; v.err = 0; v.ovf = 0;
        push_evt(v);
        send_line("HI");
        drive("X");
        check("ovr_flag", overrun, 1);
        check("ovr_ready", line_ready, 1);
        check("ovr_len", line_len, 2);
        readback("ovr", "HI");
        do_reset();
        check("ovr_rst_flag", overrun, 0);
        check("ovr_rst_ready", line_ready, 0);

        // Byte and ack in the same cycle: byte dropped, overrun set, released.
        v.txt = "AT";
        push_evt(v);
        send_line("AT");
        rx_data  = "Z";
        rx_valid = 1'b1;
        line_ack = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        line_ack = 1'b0;
        check("both_ready", line_ready, 0);
        check("both_len", line_len, 0);
        check("both_overrun", overrun, 1);
        v.txt = "OK"; v.ok = 1;
        push_evt(v);
        send_line("OK");
        readback("after_both", "OK");
        ack_line("after_both");

        // Reset mid-line abandons it with no pulses.
        do_reset();
        drive(8'h0A); drive(8'h0D); drive(8'h0A); drive("O"); drive("K");
        do_reset();
        drive(8'h0D); drive(8'h0A);
        repeat (3) @(posedge clk);
        #1;
        check("midrst_ready", line_ready, 0);
        check("midrst_len", line_len, 0);

        check("queue_empty", evq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
